// File: rtl/e_counter_monitor_pkg.sv
// Shared definitions for the wrap-counter monitor: FSM state encoding and the
// layout of the packed status word, so RTL and benches decode it identically.
package e_counter_monitor_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } mon_state_t;

  // Status word is {locked, err, overflow, err_count}; flag bit index = ERR_WIDTH + FLAG_*.
  localparam int NUM_FLAGS     = 3;
  localparam int FLAG_LOCKED   = 2;
  localparam int FLAG_ERR      = 1;
  localparam int FLAG_OVERFLOW = 0;

  function automatic int status_width(input int err_width);
    return err_width + NUM_FLAGS;
  endfunction

endpackage

// File: rtl/e_wrap_next.sv
// Next value of a counter that runs 0..max and wraps to 0; never passes max,
// so max = all-ones wraps without relying on arithmetic overflow.
module e_wrap_next #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] next
);

  assign next = (prev == max) ? '0 : prev + WIDTH'(1);

endmodule

// File: rtl/e_counter_monitor.sv
// Checks a sampled wrap-counter stream against the 0..max wrap rule, tracks lock
// and keeps a saturating count of mismatches seen while locked.
module e_counter_monitor
  import e_counter_monitor_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ERR_WIDTH  = 16,
  parameter int LOCK_COUNT = 2
) (
  input  logic                   _i_clk,
  input  logic                   _i_rst,
  input  logic [WIDTH-1:0]       _i_max,
  input  logic                   _i_valid,
  input  logic [WIDTH-1:0]       _i_value,
  output logic [ERR_WIDTH+2:0]   __output
);

  // Handshake: _i_value is a sample only in cycles with _i_valid=1; there is no
  // backpressure, every valid sample is consumed at that rising edge.

  localparam int GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  mon_state_t           state;
  logic                 have_prev;
  logic [WIDTH-1:0]     prev;
  logic [GW-1:0]        good;
  logic                 err;
  logic                 overflow;
  logic [ERR_WIDTH-1:0] err_count;
  logic [WIDTH-1:0]     expected;
  logic                 match;
  logic [GW-1:0]        good_inc;

  e_wrap_next #(.WIDTH(WIDTH)) u_wrap_next (
    .prev (prev),
    .max  (_i_max),
    .next (expected)
  );

  // Range check catches values above max even when they equal prev+1.
  assign match    = have_prev && (_i_value == expected) && (_i_value <= _i_max);
  assign good_inc = good + GW'(1);

  always_ff @(posedge _i_clk) begin
    if (_i_rst) begin
      state     <= UNLOCKED;
      have_prev <= 1'b0;
      prev      <= '0;
      good      <= '0;
      err       <= 1'b0;
      overflow  <= 1'b0;
      err_count <= '0;
    end else begin
      err <= 1'b0;
      if (_i_valid) begin
        prev      <= _i_value;
        have_prev <= 1'b1;
        case (state)
          UNLOCKED: begin
            state <= LOCKING;
            good  <= '0;
          end
          LOCKING: begin
            if (!match) begin
              good <= '0;
            end else if (good_inc == GW'(LOCK_COUNT)) begin
              state <= LOCKED;
              good  <= '0;
            end else begin
              good <= good_inc;
            end
          end
          LOCKED: begin
            if (!match) begin
              // Resync straight from the offending value rather than via UNLOCKED.
              err   <= 1'b1;
              state <= LOCKING;
              good  <= '0;
              if (&err_count) overflow <= 1'b1;
              else            err_count <= err_count + ERR_WIDTH'(1);
            end
          end
          default: begin
            state <= UNLOCKED;
            good  <= '0;
          end
        endcase
      end
    end
  end

  assign __output = {(state == LOCKED), err, overflow, err_count};

endmodule

// File: tb/tb_e_counter_monitor.sv
// Directed bench for e_counter_monitor: lock/unlock sequencing, error pulse and
// saturation, wrap boundaries and a live wrap-counter source.
module tb_e_counter_monitor;
  import e_counter_monitor_pkg::*;

  localparam int W   = 8;
  localparam int EW  = 16;
  localparam int EW2 = 2;

  // clock / reset
  logic           clk = 1'b0;
  logic           rst;
  logic           valid;
  logic [W-1:0]   max;
  logic [W-1:0]   value;
  logic [EW+2:0]  out_main;
  logic [EW2+2:0] out_small;

  int checks = 0;
  int errors = 0;

  always #1 clk = ~clk;

  e_counter_monitor #(.WIDTH(W), .ERR_WIDTH(EW), .LOCK_COUNT(2)) dut (
    ._i_clk   (clk),
    ._i_rst   (rst),
    ._i_max   (max),
    ._i_valid (valid),
    ._i_value (value),
    .__output (out_main)
  );

  e_counter_monitor #(.WIDTH(W), .ERR_WIDTH(EW2), .LOCK_COUNT(2)) dut_small (
    ._i_clk   (clk),
    ._i_rst   (rst),
    ._i_max   (max),
    ._i_valid (valid),
    ._i_value (value),
    .__output (out_small)
  );

  // checking helpers
  function automatic logic [EW+2:0] pk(input logic l, input logic e, input logic o,
                                       input logic [EW-1:0] c);
    return {l, e, o, c};
  endfunction

  function automatic logic [EW2+2:0] pks(input logic l, input logic e, input logic o,
                                         input logic [EW2-1:0] c);
    return {l, e, o, c};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change on negedge, outputs read on the following negedge
  task automatic sample(input logic [W-1:0] v);
    valid = 1'b1;
    value = v;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    valid = 1'b1;
    value = 8'h55;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    valid = 1'b0;
  endtask

  logic [W-1:0] cur;
  logic         got_lock;

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    value = '0;
    max   = 8'd2;
    @(negedge clk);

    // reset, with valid asserted to show reset dominates
    do_reset();
    check("rst_main", 32'(out_main), 32'(pk(0, 0, 0, 0)));
    check("rst_small", 32'(out_small), 32'(pks(0, 0, 0, 0)));

    // basic lock on 0,1,2,0,1
    sample(0); check("lk_s0", 32'(out_main), 32'(pk(0, 0, 0, 0)));
    sample(1); check("lk_s1", 32'(out_main), 32'(pk(0, 0, 0, 0)));
    sample(2); check("lk_s2", 32'(out_main), 32'(pk(1, 0, 0, 0)));
    sample(0); check("lk_s3", 32'(out_main), 32'(pk(1, 0, 0, 0)));
    sample(1); check("lk_s4", 32'(out_main), 32'(pk(1, 0, 0, 0)));

    // mismatch while locked, one-cycle err pulse, resync from new value
    sample(2); check("mm_ok", 32'(out_main), 32'(pk(1, 0, 0, 0)));
    sample(1); check("mm_err", 32'(out_main), 32'(pk(0, 1, 0, 1)));
    idle(1);   check("mm_pulse", 32'(out_main), 32'(pk(0, 0, 0, 1)));
    sample(2); check("mm_rs1", 32'(out_main), 32'(pk(0, 0, 0, 1)));
    sample(0); check("mm_rs2", 32'(out_main), 32'(pk(1, 0, 0, 1)));
    sample(1); check("mm_rs3", 32'(out_main), 32'(pk(1, 0, 0, 1)));
    check("mm_small", 32'(out_small), 32'(pks(1, 0, 0, 1)));

    // valid=0 gaps hold lock, then out-of-range value
    do_reset();
    sample(0); sample(1); sample(2);
    idle(3);   check("gap_hold", 32'(out_main), 32'(pk(1, 0, 0, 0)));
    sample(3); check("oor_err", 32'(out_main), 32'(pk(0, 1, 0, 1)));
    idle(1);   check("oor_pulse", 32'(out_main), 32'(pk(0, 0, 0, 1)));

    // value == prev+1 but above a lowered max is still a mismatch
    do_reset();
    max = 8'd3;
    sample(0); sample(1); sample(2);
    check("rng_lock", 32'(out_main), 32'(pk(1, 0, 0, 0)));
    max = 8'd1;
    sample(3); check("rng_err", 32'(out_main), 32'(pk(0, 1, 0, 1)));

    // five locked mismatches: small counter saturates at 3 and sets overflow
    do_reset();
    max = 8'd2;
    sample(0); sample(1); sample(2);
    cur = 8'd2;
    for (int k = 0; k < 5; k++) begin
      sample(cur);
      check("sat_main_err", 32'(out_main), 32'(pk(0, 1, 0, EW'(k + 1))));
      check("sat_small_err", 32'(out_small),
            32'(pks(0, 1, (k >= 3), (k < 3) ? EW2'(k + 1) : EW2'(3))));
      cur = (cur == max) ? '0 : cur + 8'd1;
      sample(cur);
      cur = (cur == max) ? '0 : cur + 8'd1;
      sample(cur);
      check("sat_relock", 32'(out_main), 32'(pk(1, 0, 0, EW'(k + 1))));
    end
    check("sat_small_end", 32'(out_small), 32'(pks(1, 0, 1, 3)));
    do_reset();
    check("sat_rst_main", 32'(out_main), 32'(pk(0, 0, 0, 0)));
    check("sat_rst_small", 32'(out_small), 32'(pks(0, 0, 0, 0)));

    // max = 2^W-1 wrap, then max = 0 constant stream
    max = 8'd255;
    sample(254); sample(255);
    check("w255_pre", 32'(out_main), 32'(pk(0, 0, 0, 0)));
    sample(0); check("w255_lock", 32'(out_main), 32'(pk(1, 0, 0, 0)));
    sample(1); check("w255_hold", 32'(out_main), 32'(pk(1, 0, 0, 0)));
    do_reset();
    max = 8'd0;
    sample(0); sample(0);
    check("m0_pre", 32'(out_main), 32'(pk(0, 0, 0, 0)));
    sample(0); check("m0_lock", 32'(out_main), 32'(pk(1, 0, 0, 0)));
    sample(0); check("m0_hold", 32'(out_main), 32'(pk(1, 0, 0, 0)));

    // live wrap counter (max=2) driving every cycle
    do_reset();
    max      = 8'd2;
    value    = '0;
    valid    = 1'b1;
    got_lock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      value = (value == max) ? '0 : value + 8'd1;
      if (out_main[EW + FLAG_LOCKED]) got_lock = 1'b1;
    end
    check("ecnt_lock", 32'(got_lock), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      value = (value == max) ? '0 : value + 8'd1;
    end
    check("ecnt_run", 32'(out_main), 32'(pk(1, 0, 0, 0)));
    valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
